// File: rtl/port_scheduler.sv
// Four-queue round-robin scheduler moving one word at a time to a registered output port.
// Optional `PKT_LOCK_EN keeps the grant on one queue until a word with EOP=1 has been sent.
module port_scheduler #(
    parameter int DATA_W = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          rd_en,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_src,
    output logic                busy
);

`ifdef PKT_LOCK_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        SEND   = 3'd3,
        LOCKED = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        SEND   = 3'd3
    } state_t;
`endif

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          grant_r;
    logic [1:0]          grant_s;
    logic [1:0]          last_r;
    logic [DATA_W-1:0]   slice_s;
    logic [3:0]          rd_en_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic [1:0]          out_src_r;
    logic                busy_r;

    // First requester scanning last+1, last+2, last+3, last (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last_v;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_v + 2'(k);
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Select the rd_data slice of the granted queue.
    always_comb begin
        slice_s = '0;
        case (grant_r)
            2'd0:    slice_s = in_data[0*DATA_W +: DATA_W];
            2'd1:    slice_s = in_data[1*DATA_W +: DATA_W];
            2'd2:    slice_s = in_data[2*DATA_W +: DATA_W];
            2'd3:    slice_s = in_data[3*DATA_W +: DATA_W];
            default: slice_s = '0;
        endcase
    end

    // Next-state and grant selection.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    grant_s = rr_pick(req, last_r);
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: state_s = LOAD;
            LOAD: state_s = SEND;
            SEND: begin
                if (out_ready) begin
`ifdef PKT_LOCK_EN
                    // Mid-packet: stay on this queue, waiting in LOCKED if it is momentarily empty.
                    if (out_data_r[DATA_W-1]) begin
                        state_s = IDLE;
                    end else if (req[grant_r]) begin
                        state_s = READ;
                    end else begin
                        state_s = LOCKED;
                    end
`else
                    state_s = IDLE;
`endif
                end else begin
                    state_s = SEND;
                end
            end
`ifdef PKT_LOCK_EN
            LOCKED: begin
                if (req[grant_r]) begin
                    state_s = READ;
                end else begin
                    state_s = LOCKED;
                end
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // State, grant history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_r     <= 2'd0;
            last_r      <= 2'd3;
            rd_en_r     <= 4'b0000;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_src_r   <= 2'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            busy_r  <= (state_s != IDLE);
            if (state_s == READ) begin
                last_r  <= grant_s;
                rd_en_r <= 4'b0001 << grant_s;
            end else begin
                last_r  <= last_r;
                rd_en_r <= 4'b0000;
            end
            if (state_r == LOAD) begin
                out_data_r  <= slice_s;
                out_src_r   <= grant_r;
                out_valid_r <= 1'b1;
            end else if (state_r == SEND && out_ready) begin
                out_data_r  <= out_data_r;
                out_src_r   <= out_src_r;
                out_valid_r <= 1'b0;
            end else begin
                out_data_r  <= out_data_r;
                out_src_r   <= out_src_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign rd_en     = rd_en_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_port_scheduler.sv
// Directed table-driven bench for port_scheduler; packet-lock expectations follow `PKT_LOCK_EN.
module tb_port_scheduler;
    localparam int DW = 33;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] in_data;
    logic [3:0]      rd_en;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_src;
    logic            busy;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] base;
        logic [3:0]  exp_rd;
        logic [1:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    port_scheduler #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .rd_en(rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        in_data = {w3, w2, w1, w0};
    endtask

    initial begin
        // Round-robin chain starting from last=3 after reset; slice i carries {EOP=1, base+i}.
        vecs[0]  = '{4'b0001, 32'd25,  4'b0001, 2'd0, 32'd25};
        vecs[1]  = '{4'b1111, 32'd40,  4'b0010, 2'd1, 32'd41};
        vecs[2]  = '{4'b1111, 32'd50,  4'b0100, 2'd2, 32'd52};
        vecs[3]  = '{4'b1111, 32'd60,  4'b1000, 2'd3, 32'd63};
        vecs[4]  = '{4'b1111, 32'd70,  4'b0001, 2'd0, 32'd70};
        vecs[5]  = '{4'b1010, 32'd80,  4'b0010, 2'd1, 32'd81};
        vecs[6]  = '{4'b1000, 32'd90,  4'b1000, 2'd3, 32'd93};
        vecs[7]  = '{4'b0110, 32'd100, 4'b0010, 2'd1, 32'd101};
        vecs[8]  = '{4'b0101, 32'd110, 4'b0100, 2'd2, 32'd112};
        vecs[9]  = '{4'b0100, 32'd120, 4'b0100, 2'd2, 32'd122};
        vecs[10] = '{4'b1001, 32'd130, 4'b1000, 2'd3, 32'd133};

        rst = 1'b1; req = 4'b0000; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 11; i++) begin
            set_words({1'b1, vecs[i].base}, {1'b1, vecs[i].base + 32'd1},
                      {1'b1, vecs[i].base + 32'd2}, {1'b1, vecs[i].base + 32'd3});
            req = vecs[i].req;
            tick();
            check($sformatf("v%0d_rd_en", i), 64'(rd_en), 64'(vecs[i].exp_rd));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            tick();
            check($sformatf("v%0d_rd_pulse", i), 64'(rd_en), 64'd0);
            check($sformatf("v%0d_load_valid", i), 64'(out_valid), 64'd0);
            tick();
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_data", i), 64'(out_data), 64'({1'b1, vecs[i].exp_data}));
            check($sformatf("v%0d_src", i), 64'(out_src), 64'(vecs[i].exp_src));
            tick();
            check($sformatf("v%0d_done", i), 64'(out_valid), 64'd0);
        end

        // Back-pressure: word 78 from queue 2 held while out_ready=0.
        req = 4'b0100; out_ready = 1'b0;
        set_words({1'b1, 32'd1}, {1'b1, 32'd2}, {1'b1, 32'd78}, {1'b1, 32'd4});
        tick();
        check("stall_rd_en", 64'(rd_en), 64'b0100);
        tick(); tick();
        check("stall_first_data", 64'(out_data), 64'({1'b1, 32'd78}));
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_data", c), 64'(out_data), 64'({1'b1, 32'd78}));
            check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d_rd_en", c), 64'(rd_en), 64'd0);
        end
        req = 4'b0000; out_ready = 1'b1;
        tick();
        check("stall_release", 64'(out_valid), 64'd0);
        check("stall_idle", 64'(busy), 64'd0);

        // Reset during LOAD: word dropped, last back to 3.
        req = 4'b0010;
        tick();
        check("mid_rst_rd_en", 64'(rd_en), 64'b0010);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        rst = 1'b0; req = 4'b0111;
        tick();
        check("post_rst_grant", 64'(rd_en), 64'b0001);
        tick(); tick();
        check("post_rst_src", 64'(out_src), 64'd0);
        req = 4'b0000;
        tick();

        // Move last to 1 so queue 2 wins next.
        req = 4'b0010;
        set_words({1'b1, 32'd0}, {1'b1, 32'd555}, {1'b0, 32'd738}, {1'b1, 32'd0});
        tick(); tick(); tick();
        check("pre_pkt_src", 64'(out_src), 64'd1);
        req = 4'b0000;
        tick();

        // Packet from queue 2 (738 EOP=0, 739 EOP=1) with queue 1 always requesting.
        req = 4'b0110;
        tick();
        check("pkt_rd_en0", 64'(rd_en), 64'b0100);
        tick(); tick();
        check("pkt_word0", 64'(out_data), 64'({1'b0, 32'd738}));
        req = 4'b0010;
        set_words({1'b1, 32'd0}, {1'b1, 32'd555}, {1'b1, 32'd739}, {1'b1, 32'd0});
        tick();
`ifdef PKT_LOCK_EN
        check("lock_t1_busy", 64'(busy), 64'd1);
        check("lock_t1_rd_en", 64'(rd_en), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("lock_t%0d_rd_en", c + 2), 64'(rd_en), 64'd0);
            check($sformatf("lock_t%0d_busy", c + 2), 64'(busy), 64'd1);
        end
        req = 4'b0110;
        tick();
        check("lock_rd_en1", 64'(rd_en), 64'b0100);
        tick(); tick();
        check("lock_word1", 64'(out_data), 64'({1'b1, 32'd739}));
        check("lock_src1", 64'(out_src), 64'd2);
        req = 4'b0010;
        tick();
        check("lock_end_idle", 64'(busy), 64'd0);
        tick();
        check("lock_q1_grant", 64'(rd_en), 64'b0010);
`else
        check("nolock_t1_busy", 64'(busy), 64'd0);
        check("nolock_t1_rd_en", 64'(rd_en), 64'd0);
        tick();
        check("nolock_q1_grant", 64'(rd_en), 64'b0010);
        tick(); tick();
        check("nolock_q1_data", 64'(out_data), 64'({1'b1, 32'd555}));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
